// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: frame-controller states and default frame geometry.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned DefaultPrescale  = 8;
  localparam int unsigned DefaultDataWidth = 8;

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Per-bit edge counter and data-bit counter for the UART receive frame controller.
module uart_edge_bit_counter #(
  parameter int unsigned Prescale  = 8,
  parameter int unsigned DataWidth = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       bit_en_i,
  output logic [4:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o,
  output logic       bit_done_o,
  output logic       last_data_bit_o
);

  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;

  assign bit_done_o      = en_i && (edge_cnt_q == 5'(Prescale - 1));
  assign last_data_bit_o = (bit_cnt_q == 4'(DataWidth - 1));
  assign edge_cnt_o      = edge_cnt_q;
  assign bit_cnt_o       = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (en_i) begin
      edge_cnt_d = bit_done_o ? 5'd0 : edge_cnt_q + 5'd1;
      if (bit_en_i && bit_done_o) begin
        bit_cnt_d = last_data_bit_o ? 4'd0 : bit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialisation,
// parity/stop checking and one-cycle outcome pulses.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE   = DefaultPrescale,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned SAMPLE_IDX = PRESCALE / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [4:0]            edge_cnt,
  output logic                  data_sample_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  rx_state_e             state_q, state_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_flag_q, par_flag_d;
  logic                  samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic       cnt_en, cnt_clr, bit_done, last_data_bit, cap, bit_val;
  logic [3:0] bit_cnt;

  assign cnt_en = (state_q != StIdle);

  uart_edge_bit_counter #(
    .Prescale  (PRESCALE),
    .DataWidth (DATA_WIDTH)
  ) u_counter (
    .clk             (clk),
    .rst             (rst),
    .en_i            (cnt_en),
    .clr_i           (cnt_clr),
    .bit_en_i        (state_q == StData),
    .edge_cnt_o      (edge_cnt),
    .bit_cnt_o       (bit_cnt),
    .bit_done_o      (bit_done),
    .last_data_bit_o (last_data_bit)
  );

  // When the sample point coincides with the wrap, use the live bit rather than the stored one.
  assign cap     = cnt_en && (edge_cnt == 5'(SAMPLE_IDX));
  assign bit_val = cap ? sampled_bit : samp_q;

  always_comb begin
    state_d      = state_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_flag_d   = par_flag_q;
    samp_d       = bit_val;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    cnt_clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d    = StStart;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_flag_d = 1'b0;
        end
      end
      StStart: begin
        if (cap && sampled_bit) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else if (bit_done) begin
          state_d = StData;
        end
      end
      StData: begin
        if (cap) begin
          for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt == 4'(i)) shift_d[i] = sampled_bit;
          end
        end
        if (bit_done && last_data_bit) state_d = par_en_q ? StParity : StStop;
      end
      StParity: begin
        if (cap && (sampled_bit != ((^shift_q) ^ par_typ_q))) par_flag_d = 1'b1;
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (bit_done) begin
          stp_err_d = ~bit_val;
          par_err_d = par_flag_q;
          if (bit_val && !par_flag_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          if (!RX_IN) begin
            state_d    = StStart;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            par_flag_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_flag_q   <= 1'b0;
      samp_q       <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_flag_q   <= par_flag_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign data_sample_en = busy;
  assign P_DATA         = p_data_q;
  assign data_valid     = data_valid_q;
  assign par_err        = par_err_q;
  assign stp_err        = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: serial frames are built from a bit list and
// the expected outcome (cycle, pulse kind, P_DATA) is computed from frame rules.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned P  = 8;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] pd;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          sampled_bit = 1'b1;
  logic [4:0]    edge_cnt;
  logic          data_sample_en;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, busy;

  logic [31:0]   cyc = '0;
  ev_t           got_q[$];
  ev_t           exp_q[$];
  int            got_base = 0;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] last_good = '0;

  uart_rx_frame_ctrl #(
    .PRESCALE   (P),
    .DATA_WIDTH (DW),
    .SAMPLE_IDX (P / 2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .RX_IN          (RX_IN),
    .PAR_EN         (PAR_EN),
    .PAR_TYP        (PAR_TYP),
    .sampled_bit    (sampled_bit),
    .edge_cnt       (edge_cnt),
    .data_sample_en (data_sample_en),
    .P_DATA         (P_DATA),
    .data_valid     (data_valid),
    .par_err        (par_err),
    .stp_err        (stp_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the mid-bit sampler: it updates on the falling edge.
  always @(negedge clk) sampled_bit <= RX_IN;

  always @(negedge clk) begin
    if (rst && (data_valid || par_err || stp_err)) begin
      got_q.push_back({cyc, data_valid, par_err, stp_err, P_DATA});
    end
  end

  // Each bit is held for P cycles; config is scrambled mid-frame as it must be ignored.
  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (P) begin
      @(posedge clk);
      #1;
      PAR_EN  = 1'($urandom);
      PAR_TYP = 1'($urandom);
    end
  endtask

  task automatic idle(input int unsigned n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic par_bit, input logic stop_bit);
    ev_t         e;
    logic        perr;
    int unsigned n;
    PAR_EN  = pe;
    PAR_TYP = pt;
    n       = (2 + DW + (pe ? 1 : 0)) * P;
    perr    = pe && (par_bit != ((^d) ^ pt));
    e.cyc   = cyc + 32'(1 + n);
    e.pe    = perr;
    e.se    = ~stop_bit;
    e.dv    = !perr && stop_bit;
    if (e.dv) last_good = d;
    e.pd    = last_good;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
    if (pe) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    RX_IN = 1'b1;
    rst   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (data_sample_en !== 1'b0) begin
      errors++; $display("FAIL reset_sample_en: got %b required 0", data_sample_en);
    end
    checks++;
    if (edge_cnt !== 5'd0) begin errors++; $display("FAIL reset_edge_cnt: got %0d required 0", edge_cnt); end
    checks++;
    if (P_DATA !== '0) begin errors++; $display("FAIL reset_p_data: got %h required 00", P_DATA); end
    checks++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b%b%b required 000", data_valid, par_err, stp_err);
    end
    rst = 1'b1;
    idle(4);
    checks++;
    if (busy !== 1'b0 || edge_cnt !== 5'd0) begin
      errors++; $display("FAIL reset_idle_line: got busy=%b edge_cnt=%0d required 0/0", busy, edge_cnt);
    end
  endtask

  task automatic test_good_frame;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (got_q.size() != got_base + exp_q.size()) begin
      errors++; $display("FAIL good_frame_count: got %0d pulses required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_base + i >= got_q.size()) begin
        errors++; $display("FAIL good_frame_ev%0d: got none required cyc=%0d", i, exp_q[i].cyc);
      end else if (got_q[got_base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL good_frame_ev%0d: got cyc=%0d dv%b pe%b se%b P_DATA=%h required cyc=%0d dv%b pe%b se%b P_DATA=%h",
                 i, got_q[got_base+i].cyc, got_q[got_base+i].dv, got_q[got_base+i].pe,
                 got_q[got_base+i].se, got_q[got_base+i].pd, exp_q[i].cyc, exp_q[i].dv,
                 exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end
    end
    got_base = got_q.size();
    exp_q.delete();
    checks++;
    if (P_DATA !== 8'hA5) begin errors++; $display("FAIL good_frame_hold: got %h required a5", P_DATA); end
  endtask

  task automatic test_parity_error;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (got_q.size() != got_base + exp_q.size()) begin
      errors++; $display("FAIL parity_err_count: got %0d pulses required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_base + i >= got_q.size()) begin
        errors++; $display("FAIL parity_err_ev%0d: got none required cyc=%0d", i, exp_q[i].cyc);
      end else if (got_q[got_base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_err_ev%0d: got cyc=%0d dv%b pe%b se%b P_DATA=%h required cyc=%0d dv%b pe%b se%b P_DATA=%h",
                 i, got_q[got_base+i].cyc, got_q[got_base+i].dv, got_q[got_base+i].pe,
                 got_q[got_base+i].se, got_q[got_base+i].pd, exp_q[i].cyc, exp_q[i].dv,
                 exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_stop_error;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    checks++;
    if (got_q.size() != got_base + exp_q.size()) begin
      errors++; $display("FAIL stop_err_count: got %0d pulses required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_base + i >= got_q.size()) begin
        errors++; $display("FAIL stop_err_ev%0d: got none required cyc=%0d", i, exp_q[i].cyc);
      end else if (got_q[got_base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stop_err_ev%0d: got cyc=%0d dv%b pe%b se%b P_DATA=%h required cyc=%0d dv%b pe%b se%b P_DATA=%h",
                 i, got_q[got_base+i].cyc, got_q[got_base+i].dv, got_q[got_base+i].pe,
                 got_q[got_base+i].se, got_q[got_base+i].pd, exp_q[i].cyc, exp_q[i].dv,
                 exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_start_glitch;
    RX_IN = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || data_sample_en !== 1'b1 || edge_cnt !== 5'd0) begin
      errors++;
      $display("FAIL glitch_enter: got busy=%b en=%b edge_cnt=%0d required 1/1/0", busy, data_sample_en, edge_cnt);
    end
    repeat (2) begin @(posedge clk); #1; end
    RX_IN = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || edge_cnt !== 5'd4) begin
      errors++; $display("FAIL glitch_count: got busy=%b edge_cnt=%0d required 1/4", busy, edge_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || data_sample_en !== 1'b0 || edge_cnt !== 5'd0) begin
      errors++;
      $display("FAIL glitch_abort: got busy=%b en=%b edge_cnt=%0d required 0/0/0", busy, data_sample_en, edge_cnt);
    end
    idle(100);
    checks++;
    if (got_q.size() != got_base) begin
      errors++; $display("FAIL glitch_no_pulse: got %0d pulses required 0", got_q.size() - got_base);
    end
    got_base = got_q.size();
  endtask

  task automatic test_back_to_back;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    checks++;
    if (got_q.size() != got_base + exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d pulses required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_base + i >= got_q.size()) begin
        errors++; $display("FAIL b2b_ev%0d: got none required cyc=%0d", i, exp_q[i].cyc);
      end else if (got_q[got_base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_ev%0d: got cyc=%0d dv%b pe%b se%b P_DATA=%h required cyc=%0d dv%b pe%b se%b P_DATA=%h",
                 i, got_q[got_base+i].cyc, got_q[got_base+i].dv, got_q[got_base+i].pe,
                 got_q[got_base+i].se, got_q[got_base+i].pd, exp_q[i].cyc, exp_q[i].dv,
                 exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_midframe_reset;
    logic [DW-1:0] d;
    d       = 8'hC3;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    RX_IN   = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    RX_IN = d[3];
    repeat (P / 2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, data_sample_en, data_valid, par_err, stp_err} !== 5'b0 || edge_cnt !== 5'd0 ||
        P_DATA !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b en=%b dv%b pe%b se%b edge_cnt=%0d P_DATA=%h required all 0",
               busy, data_sample_en, data_valid, par_err, stp_err, edge_cnt, P_DATA);
    end
    RX_IN = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    last_good = '0;
    idle(4);
    checks++;
    if (got_q.size() != got_base) begin
      errors++; $display("FAIL midreset_no_pulse: got %0d pulses required 0", got_q.size() - got_base);
    end
    got_base = got_q.size();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    checks++;
    if (got_q.size() != got_base + exp_q.size()) begin
      errors++; $display("FAIL midreset_count: got %0d pulses required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_base + i >= got_q.size()) begin
        errors++; $display("FAIL midreset_ev%0d: got none required cyc=%0d", i, exp_q[i].cyc);
      end else if (got_q[got_base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_ev%0d: got cyc=%0d dv%b pe%b se%b P_DATA=%h required cyc=%0d dv%b pe%b se%b P_DATA=%h",
                 i, got_q[got_base+i].cyc, got_q[got_base+i].dv, got_q[got_base+i].pe,
                 got_q[got_base+i].se, got_q[got_base+i].pd, exp_q[i].cyc, exp_q[i].dv,
                 exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [DW-1:0] d;
    logic          pe, pt, par_ok, stop_ok;
    int unsigned   gap;
    for (int k = 0; k < 24; k++) begin
      d       = DW'($urandom);
      pe      = 1'($urandom);
      pt      = 1'($urandom);
      par_ok  = ($urandom_range(0, 3) != 0);
      stop_ok = ($urandom_range(0, 3) != 0);
      gap     = $urandom_range(0, 3);
      send_frame(d, pe, pt, par_ok ? ((^d) ^ pt) : ~((^d) ^ pt), stop_ok);
      if (gap != 0) idle(gap);
    end
    idle(4);
    checks++;
    if (got_q.size() != got_base + exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d pulses required %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_base + i >= got_q.size()) begin
        errors++; $display("FAIL random_ev%0d: got none required cyc=%0d", i, exp_q[i].cyc);
      end else if (got_q[got_base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_ev%0d: got cyc=%0d dv%b pe%b se%b P_DATA=%h required cyc=%0d dv%b pe%b se%b P_DATA=%h",
                 i, got_q[got_base+i].cyc, got_q[got_base+i].dv, got_q[got_base+i].pe,
                 got_q[got_base+i].se, got_q[got_base+i].pd, exp_q[i].cyc, exp_q[i].dv,
                 exp_q[i].pe, exp_q[i].se, exp_q[i].pd);
      end
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity_error;
    test_stop_error;
    test_start_glitch;
    test_back_to_back;
    test_midframe_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
